fifo_serial_tx: RTL

Serial transmit stage sitting directly downstream of the 6-bit word FIFO. It pops one word at a time through the FIFO read port and transmits it on a single-wire asynchronous line. Frame format: one start bit, WIDTH data bits LSB first, an optional even-parity bit and one stop bit. It also reports busy status and a running frame count for debug pins.

---
 rtl/fifo_serial_tx.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx: pops one word at a time from the upstream word FIFO and
// sends it on a single-wire async line (start, WIDTH data bits LSB first,
// optional even parity, one stop bit). Busy and a frame counter are
// exported for debug pins.
module fifo_serial_tx #(
  parameter int WIDTH        = 6,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_read_en,
  output logic             tx,
  output logic             busy,
  output logic [7:0]       frame_count
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(WIDTH + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LATCH,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  sr;
  logic              par;
  logic [BAUD_W-1:0] baud_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic              baud_done;

  // Terminal count of the per-bit baud counter.
  always_comb begin
    baud_done = (baud_cnt == BAUD_LAST);
  end

  // Frame sequencer; tx is loaded one edge ahead so it is registered yet
  // still shows the current bit for the full CLKS_PER_BIT cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      sr           <= '0;
      par          <= 1'b0;
      baud_cnt     <= '0;
      bit_cnt      <= '0;
      fifo_read_en <= 1'b0;
      tx           <= 1'b1;
      busy         <= 1'b0;
      frame_count  <= '0;
    end else begin
      fifo_read_en <= 1'b0;
      case (state)
        IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          if (enable && !fifo_empty) begin
            state        <= POP;
            fifo_read_en <= 1'b1;
            busy         <= 1'b1;
          end
        end
        POP: begin
          state <= LATCH;
        end
        LATCH: begin
          sr       <= fifo_data;
          par      <= (PARITY_EN != 0) ? ^fifo_data : 1'b0;
          bit_cnt  <= '0;
          baud_cnt <= '0;
          tx       <= 1'b0;
          state    <= START;
        end
        START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            tx       <= sr[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            sr       <= sr >> 1;
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) begin
              if (PARITY_EN != 0) begin
                tx    <= par;
                state <= PARITY;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              // sr[1] becomes sr[0] at this same edge.
              tx <= sr[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (baud_done) begin
            baud_cnt <= '0;
            tx       <= 1'b1;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_done) begin
            baud_cnt    <= '0;
            busy        <= 1'b0;
            frame_count <= frame_count + 1'b1;
            state       <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
